// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use bubbles,
// redirect flushes, data-memory wait freezes with a timeout watchdog.
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_regdest,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WCNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_run;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic w_memstall;
  logic w_loaduse;
  logic w_rs_hit;
  logic w_rt_hit;

  assign w_memstall = mem_req & ~mem_ready;
  assign w_rs_hit   = id_uses_rs & (id_rs == ex_regdest);
  assign w_rt_hit   = id_uses_rt & (id_rt == ex_regdest);
  assign w_loaduse  = ex_memread & (ex_regdest != 5'd0) & (w_rs_hit | w_rt_hit);

  // Same-cycle enable/flush decode: memstall > redirect > load-use > normal
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (r_run && (r_state != S_ERR)) begin
      if (w_memstall) begin
        pc_en = 1'b0;
      end else if (ex_redirect) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (w_loaduse) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  // Wait/timeout FSM, run flag and saturating stall counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_RUN;
      r_run          <= 1'b0;
      r_wait_cnt     <= '0;
      r_mem_err      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        case (r_state)
          S_RUN: begin
            if (w_memstall) begin
              r_state    <= S_WAIT;
              r_wait_cnt <= WCNT_W'(1);
            end
          end
          S_WAIT: begin
            if (!w_memstall) begin
              r_state    <= S_RUN;
              r_wait_cnt <= '0;
            end else if (r_wait_cnt == WCNT_W'(MAX_WAIT)) begin
              r_state   <= S_ERR;
              r_mem_err <= 1'b1;
            end else begin
              r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
            end
          end
          S_ERR:   r_state <= S_ERR;
          default: r_state <= S_ERR;
        endcase
        if (!pc_en && (r_stall_cycles != {CNT_W{1'b1}}))
          r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end

  assign mem_err      = r_mem_err;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a rule-level reference model
// compared every cycle, plus literal spot checks.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MAX_WAIT  = 4;
  localparam int unsigned CNT_W     = 4;
  localparam int          STALL_MAX = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic [4:0]       id_rs = '0, id_rt = '0, ex_regdest = '0;
  logic             id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_memread = 1'b0;
  logic             ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, mem_err;
  logic [CNT_W-1:0] stall_cycles;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  bit         m_run;
  bit         m_err;
  int         m_consec;
  int         m_stall;
  logic [6:0] m_e;

  pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_regdest(ex_regdest), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush} from the hazard rules
  function automatic logic [6:0] exp_vec();
    bit hazard_lu;
    hazard_lu = ex_memread && (ex_regdest != 0) &&
                ((id_uses_rs && id_rs == ex_regdest) || (id_uses_rt && id_rt == ex_regdest));
    if (!m_run || m_err)             return 7'b00000_00;
    if (mem_req && !mem_ready)       return 7'b00000_00;
    if (ex_redirect)                 return 7'b11111_11;
    if (hazard_lu)                   return 7'b00111_01;
    return 7'b11111_00;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_run = 0; m_err = 0; m_consec = 0; m_stall = 0;
    end else begin
      m_e = exp_vec();
      if (m_run) begin
        if (!m_e[6] && m_stall < STALL_MAX) m_stall++;
        if (!m_err) begin
          if (mem_req && !mem_ready) begin
            m_consec++;
            if (m_consec == MAX_WAIT + 1) m_err = 1;
          end else begin
            m_consec = 0;
          end
        end
      end
      m_run = 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      logic [6:0] got, exp;
      got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
      exp = exp_vec();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL model_ctrl t=%0t got=%b exp=%b", $time, got, exp);
      end
      checks++;
      if (mem_err !== m_err) begin
        failures++;
        $display("FAIL model_err t=%0t got=%b exp=%b", $time, mem_err, m_err);
      end
      checks++;
      if (int'(stall_cycles) != m_stall) begin
        failures++;
        $display("FAIL model_stall t=%0t got=%0d exp=%0d", $time, stall_cycles, m_stall);
      end
    end
  end

  task automatic lit(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                       input logic urt, input logic mr, input logic [4:0] rd,
                       input logic redir, input logic req, input logic rdy);
    @(posedge clock);
    #1;
    id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    ex_memread = mr; ex_regdest = rd; ex_redirect = redir;
    mem_req = req; mem_ready = rdy;
    @(negedge clock);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    chk_en = 1'b1;
    @(negedge clock);
    lit("rst_pc_en", int'(pc_en), 0);
    lit("rst_stall", int'(stall_cycles), 0);
    lit("rst_err", int'(mem_err), 0);

    // Release: cycle 0 still idle, cycle 1 running
    @(posedge clock); #1 resetn = 1'b1;
    @(negedge clock);
    lit("rel_c0_pc_en", int'(pc_en), 0);
    lit("rel_c0_memwb_en", int'(memwb_en), 0);
    idle();
    lit("rel_c1_pc_en", int'(pc_en), 1);
    lit("rel_c1_memwb_en", int'(memwb_en), 1);

    // Load-use on rs
    drive(5, 1, 0, 0, 1, 5, 0, 0, 0);
    lit("lu_pc_en", int'(pc_en), 0);
    lit("lu_ifid_en", int'(ifid_en), 0);
    lit("lu_idex_flush", int'(idex_flush), 1);
    lit("lu_exmem_en", int'(exmem_en), 1);
    lit("lu_memwb_en", int'(memwb_en), 1);
    idle();
    lit("lu_next_pc_en", int'(pc_en), 1);
    lit("lu_stall", int'(stall_cycles), 1);
    // Load-use on rt
    drive(0, 0, 7, 1, 1, 7, 0, 0, 0);
    lit("lu_rt_pc_en", int'(pc_en), 0);
    idle();
    lit("lu_rt_stall", int'(stall_cycles), 2);
    // r0 and unused-rs never stall
    drive(0, 1, 0, 1, 1, 0, 0, 0, 0);
    lit("lu_r0_pc_en", int'(pc_en), 1);
    drive(9, 0, 3, 1, 1, 9, 0, 0, 0);
    lit("lu_unused_pc_en", int'(pc_en), 1);
    // Redirect beats load-use
    drive(5, 1, 0, 0, 1, 5, 1, 0, 0);
    lit("redir_pc_en", int'(pc_en), 1);
    lit("redir_ifid_flush", int'(ifid_flush), 1);
    lit("redir_idex_flush", int'(idex_flush), 1);
    idle();
    lit("redir_stall", int'(stall_cycles), 2);

    // Memory wait: 3 frozen cycles then ready
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    lit("mw_pc_en", int'(pc_en), 0);
    lit("mw_memwb_en", int'(memwb_en), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    lit("mw_ready_pc_en", int'(pc_en), 1);
    lit("mw_ready_flush", int'(ifid_flush), 0);
    idle();
    lit("mw_stall", int'(stall_cycles), 5);

    // Memory wait masks a redirect; flush lands in the ready cycle
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    lit("mask_ifid_flush", int'(ifid_flush), 0);
    lit("mask_pc_en", int'(pc_en), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    lit("mask_ready_ifid_flush", int'(ifid_flush), 1);
    lit("mask_ready_idex_flush", int'(idex_flush), 1);
    idle();
    lit("mask_stall", int'(stall_cycles), 7);

    // mem_req dropping ends the wait like ready; load-use then shows
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(4, 1, 0, 0, 1, 4, 0, 0, 0);
    lit("drop_lu_idex_flush", int'(idex_flush), 1);
    idle();
    lit("drop_stall", int'(stall_cycles), 9);

    // Longest tolerated wait: MAX_WAIT frozen cycles, no error
    repeat (MAX_WAIT) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle();
    lit("maxwait_err", int'(mem_err), 0);
    lit("maxwait_stall", int'(stall_cycles), 13);

    // Timeout: error after the (MAX_WAIT+1)th stalled edge, then frozen
    repeat (MAX_WAIT + 1) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    lit("to_pre_err", int'(mem_err), 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
    lit("to_err", int'(mem_err), 1);
    lit("to_pc_en", int'(pc_en), 0);
    lit("to_ifid_flush", int'(ifid_flush), 0);
    drive(5, 1, 0, 0, 1, 5, 0, 0, 0);
    idle();
    idle();
    lit("err_memwb_en", int'(memwb_en), 0);
    lit("err_stall_sat", int'(stall_cycles), STALL_MAX);

    // Asynchronous clear mid-cycle
    #2 resetn = 1'b0;
    #1;
    lit("arst_err", int'(mem_err), 0);
    lit("arst_stall", int'(stall_cycles), 0);
    lit("arst_pc_en", int'(pc_en), 0);
    idle();
    @(posedge clock); #1 resetn = 1'b1;
    @(negedge clock);
    idle();
    lit("rerun_pc_en", int'(pc_en), 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    lit("rerun_stall", int'(stall_cycles), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
